// File: rtl/axi_pulse_sequencer.sv
// axi_pulse_sequencer: programmable frame-sync pulse train generator.
// Emits cfg_num pulses (or runs freely when cfg_num is 0) with a fixed period
// and high width, all latched when a start is accepted.
// Optional build macro: PULSER_EXT_TRIG_EN. When it is defined, every pulse
// waits for a rising edge on a synchronised copy of ext_trig.
module axi_pulse_sequencer #(
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [NUM_W-1:0] cfg_num,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic             ext_trig,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TRIG = 2'd1,
        S_HIGH      = 2'd2,
        S_LOW       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;     // cycles left in the current phase, minus one
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;
    logic             pulse_q;
    logic             busy_q;

    logic             cfg_valid;
    logic             phase_last;
    logic             run_complete;
    logic [CNT_W-1:0] low_len_m1;
    logic             trig_rise;

    // Width 0 or width >= period would give a pulse with no high or no low phase.
    assign cfg_valid    = (cfg_period >= CNT_W'(2)) && (cfg_width != '0) && (cfg_width < cfg_period);
    assign phase_last   = (phase_q == '0);
    assign run_complete = (num_q != '0) && (pulse_cnt_q == num_q);
    assign low_len_m1   = period_q - width_q - CNT_W'(1);

`ifdef PULSER_EXT_TRIG_EN
    logic trig_s1_q, trig_s2_q, trig_s3_q;

    // Two-stage synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_s3_q <= 1'b0;
        end else begin
            trig_s1_q <= ext_trig;
            trig_s2_q <= trig_s1_q;
            trig_s3_q <= trig_s2_q;
        end
    end

    assign trig_rise = trig_s2_q & ~trig_s3_q;
`else
    logic unused_ext_trig;
    assign unused_ext_trig = ext_trig;
    assign trig_rise       = 1'b0;
`endif

    // Next-state, phase counter, pulse count and status logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        period_d    = period_q;
        width_d     = width_q;
        num_d       = num_q;
        pulse_cnt_d = pulse_cnt_q;
        cfg_err_d   = cfg_err_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start && !cfg_stop) begin
                    if (cfg_valid) begin
                        period_d  = cfg_period;
                        width_d   = cfg_width;
                        num_d     = cfg_num;
                        cfg_err_d = 1'b0;
`ifdef PULSER_EXT_TRIG_EN
                        state_d     = S_WAIT_TRIG;
                        pulse_cnt_d = '0;
`else
                        state_d     = S_HIGH;
                        phase_d     = cfg_width - CNT_W'(1);
                        pulse_cnt_d = NUM_W'(1);
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
`ifdef PULSER_EXT_TRIG_EN
            S_WAIT_TRIG: begin
                if (trig_rise) begin
                    state_d     = S_HIGH;
                    phase_d     = width_q - CNT_W'(1);
                    pulse_cnt_d = pulse_cnt_q + NUM_W'(1);
                end
            end
`endif
            S_HIGH: begin
                if (phase_last) begin
                    state_d = S_LOW;
                    phase_d = low_len_m1;
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            S_LOW: begin
                if (!phase_last) begin
                    phase_d = phase_q - CNT_W'(1);
                end else if (run_complete) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
`ifdef PULSER_EXT_TRIG_EN
                    state_d = S_WAIT_TRIG;
`else
                    state_d     = S_HIGH;
                    phase_d     = width_q - CNT_W'(1);
                    pulse_cnt_d = pulse_cnt_q + NUM_W'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Stop overrides everything above: abort, keep the count, no done strobe.
        if (cfg_stop && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            pulse_cnt_d = pulse_cnt_q;
            done_d      = 1'b0;
        end
    end

    // State and datapath registers; outputs registered from next-state values.
    always_ff @(posedge ACLK) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            period_q    <= '0;
            width_q     <= '0;
            num_q       <= '0;
            pulse_cnt_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            phase_q     <= phase_d;
            period_q    <= period_d;
            width_q     <= width_d;
            num_q       <= num_d;
            pulse_cnt_q <= pulse_cnt_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            pulse_q     <= (state_d == S_HIGH);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule
